// File: rtl/parking_time_controller_pkg.sv
// rtl/parking_time_controller_pkg.sv - shared constants, FSM states and fee helper for the parking time controller
package parking_time_controller_pkg;

    localparam int TIME_W = 8;
    localparam logic [TIME_W-1:0] FEE_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        RESP_ENTRY = 1'b0,
        RESP_EXIT  = 1'b1
    } resp_type_t;

    // Product is formed at 16 bits so long stays saturate instead of wrapping.
    function automatic logic [TIME_W-1:0] sat_fee(input logic [TIME_W-1:0] t, input logic [7:0] rate);
        logic [15:0] p;
        p = 16'(t) * 16'(rate);
        return (p > 16'(FEE_MAX)) ? FEE_MAX : p[TIME_W-1:0];
    endfunction

endpackage

// File: rtl/parking_time_controller_if.sv
// rtl/parking_time_controller_if.sv - request/response and status bundle between gate logic and controller
interface parking_time_controller_if #(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = 2
);
    logic                 entry_req;
    logic                 exit_req;
    logic [SLOT_W-1:0]    exit_slot;
    logic                 req_ready;
    logic                 resp_valid;
    logic                 resp_type;
    logic                 resp_err;
    logic [SLOT_W-1:0]    resp_slot;
    logic [7:0]           time_total;
    logic [7:0]           fee;
    logic [NUM_SLOTS-1:0] occupied;
    logic                 full;
    logic [7:0]           time_now;

    modport master (
        output entry_req, exit_req, exit_slot,
        input  req_ready, resp_valid, resp_type, resp_err, resp_slot,
               time_total, fee, occupied, full, time_now
    );

    modport slave (
        input  entry_req, exit_req, exit_slot,
        output req_ready, resp_valid, resp_type, resp_err, resp_slot,
               time_total, fee, occupied, full, time_now
    );
endinterface

// File: rtl/parking_time_controller_elapsed_sub.sv
// rtl/parking_time_controller_elapsed_sub.sv - shared modulo-256 elapsed-time subtractor
module elapsed_sub (
    input  logic [7:0] i_time_out,
    input  logic [7:0] i_time_in,
    output logic [7:0] o_time_total
);
    assign o_time_total = i_time_out - i_time_in;
endmodule

// File: rtl/parking_time_controller.sv
// rtl/parking_time_controller.sv - time base, slot table and IDLE/CALC/RESP session scheduler
module parking_time_controller
    import parking_time_controller_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = 2,
    parameter int TICK_DIV  = 10,
    parameter int RATE      = 2
) (
    input  logic clk,
    input  logic rst,
    parking_time_controller_if.slave bus
);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t               r_state;
    state_t               w_state_next;
    logic [PRE_W-1:0]     r_presc;
    logic [TIME_W-1:0]    r_time_now;
    logic [NUM_SLOTS-1:0] r_occupied;
    logic [TIME_W-1:0]    r_time_in [NUM_SLOTS];
    resp_type_t           r_lat_type;
    logic [SLOT_W-1:0]    r_lat_slot;
    logic [TIME_W-1:0]    r_lat_time;
    resp_type_t           r_resp_type;
    logic                 r_resp_err;
    logic [SLOT_W-1:0]    r_resp_slot;
    logic [TIME_W-1:0]    r_time_total;
    logic [TIME_W-1:0]    r_fee;

    logic                 w_tick;
    logic                 w_accept;
    logic                 w_accept_exit;
    logic                 w_req_ready;
    logic                 w_resp_valid;
    logic                 w_has_free;
    logic [SLOT_W-1:0]    w_free_slot;
    logic [TIME_W-1:0]    w_elapsed;

    assign w_tick = (r_presc == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc    <= '0;
            r_time_now <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PRE_W'(1);
            if (w_tick) begin
                r_time_now <= r_time_now + TIME_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Exit takes priority when both requests are raised in the same IDLE cycle.
    always_comb begin
        w_state_next  = r_state;
        w_req_ready   = 1'b0;
        w_resp_valid  = 1'b0;
        w_accept      = 1'b0;
        w_accept_exit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready   = 1'b1;
                w_accept_exit = bus.exit_req;
                w_accept      = bus.exit_req | bus.entry_req;
                if (w_accept) begin
                    w_state_next = ST_CALC;
                end
            end
            ST_CALC: w_state_next = ST_RESP;
            ST_RESP: begin
                w_resp_valid = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_has_free  = 1'b0;
        w_free_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!r_occupied[i]) begin
                w_has_free  = 1'b1;
                w_free_slot = SLOT_W'(i);
            end
        end
    end

    elapsed_sub u_elapsed_sub (
        .i_time_out   (r_lat_time),
        .i_time_in    (r_time_in[r_lat_slot]),
        .o_time_total (w_elapsed)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occupied   <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_time_in[i] <= '0;
            end
            r_lat_type   <= RESP_ENTRY;
            r_lat_slot   <= '0;
            r_lat_time   <= '0;
            r_resp_type  <= RESP_ENTRY;
            r_resp_err   <= 1'b0;
            r_resp_slot  <= '0;
            r_time_total <= '0;
            r_fee        <= '0;
        end else begin
            if (w_accept) begin
                r_lat_type <= w_accept_exit ? RESP_EXIT : RESP_ENTRY;
                r_lat_slot <= bus.exit_slot;
                r_lat_time <= r_time_now;
            end
            if (r_state == ST_CALC) begin
                r_resp_type <= r_lat_type;
                if (r_lat_type == RESP_ENTRY) begin
                    r_resp_err   <= !w_has_free;
                    r_resp_slot  <= w_free_slot;
                    r_time_total <= '0;
                    r_fee        <= '0;
                    if (w_has_free) begin
                        r_time_in[w_free_slot]  <= r_lat_time;
                        r_occupied[w_free_slot] <= 1'b1;
                    end
                end else begin
                    r_resp_slot <= r_lat_slot;
                    if (r_occupied[r_lat_slot]) begin
                        r_resp_err              <= 1'b0;
                        r_time_total            <= w_elapsed;
                        r_fee                   <= sat_fee(w_elapsed, 8'(RATE));
                        r_occupied[r_lat_slot]  <= 1'b0;
                    end else begin
                        r_resp_err   <= 1'b1;
                        r_time_total <= '0;
                        r_fee        <= '0;
                    end
                end
            end
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_type  = r_resp_type;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_slot  = r_resp_slot;
    assign bus.time_total = r_time_total;
    assign bus.fee        = r_fee;
    assign bus.occupied   = r_occupied;
    assign bus.full       = &r_occupied;
    assign bus.time_now   = r_time_now;

endmodule

// File: tb/tb_parking_time_controller.sv
// tb/tb_parking_time_controller.sv - randomized self-checking bench with a behavioural parking lot model
module tb_parking_time_controller;

    localparam int NS   = 4;
    localparam int SW   = 2;
    localparam int TD   = 1;
    localparam int RATE = 2;

    logic clk;
    logic rst;

    parking_time_controller_if #(.NUM_SLOTS(NS), .SLOT_W(SW)) bus ();

    parking_time_controller #(
        .NUM_SLOTS (NS),
        .SLOT_W    (SW),
        .TICK_DIV  (TD),
        .RATE      (RATE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int m_edges  = 0;
    bit m_occ [NS];
    int m_tin [NS];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) m_edges <= 0;
        else     m_edges <= m_edges + 1;
    end

    function int mtime();
        return (m_edges / TD) % 256;
    endfunction

    function logic [NS-1:0] mocc();
        logic [NS-1:0] v;
        for (int i = 0; i < NS; i++) v[i] = m_occ[i];
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_time(input int target);
        int n;
        n = 0;
        while (mtime() != target && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("wait_time", bus.time_now, target);
    endtask

    // Called at a negedge in IDLE; returns at the negedge where IDLE is reached again.
    task automatic issue(input bit want_entry, input bit want_exit, input int slot);
        int t_acc;
        bit e_err;
        int e_slot, e_total, e_fee;
        logic [1:0] s2;
        s2 = slot[1:0];
        check("ready_before", bus.req_ready, 1);
        check("time_now", bus.time_now, mtime());
        t_acc = mtime();
        bus.entry_req = want_entry;
        bus.exit_req  = want_exit;
        bus.exit_slot = s2;
        e_err = 0; e_slot = 0; e_total = 0; e_fee = 0;
        if (want_exit) begin
            e_slot = slot;
            if (!m_occ[slot]) begin
                e_err = 1;
            end else begin
                e_total = (t_acc - m_tin[slot] + 256) % 256;
                e_fee   = (e_total * RATE > 255) ? 255 : e_total * RATE;
                m_occ[slot] = 0;
            end
        end else begin
            e_err = 1;
            for (int i = NS - 1; i >= 0; i--) begin
                if (!m_occ[i]) begin
                    e_err  = 0;
                    e_slot = i;
                end
            end
            if (!e_err) begin
                m_occ[e_slot] = 1;
                m_tin[e_slot] = t_acc;
            end
        end
        @(negedge clk);
        if (want_exit) bus.exit_req = 1'b0;
        else           bus.entry_req = 1'b0;
        check("calc_ready", bus.req_ready, 0);
        check("calc_valid", bus.resp_valid, 0);
        @(negedge clk);
        check("resp_valid", bus.resp_valid, 1);
        check("resp_type", bus.resp_type, want_exit);
        check("resp_err", bus.resp_err, e_err);
        if (!e_err) check("resp_slot", bus.resp_slot, e_slot);
        check("time_total", bus.time_total, e_total);
        check("fee", bus.fee, e_fee);
        check("occupied", bus.occupied, mocc());
        check("full", bus.full, &mocc());
        @(negedge clk);
        check("ready_after", bus.req_ready, 1);
        check("valid_drop", bus.resp_valid, 0);
        check("hold_total", bus.time_total, e_total);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int r;
        int s;
        rst = 1'b1;
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
        bus.exit_slot = '0;
        for (int i = 0; i < NS; i++) begin m_occ[i] = 0; m_tin[i] = 0; end
        repeat (3) @(negedge clk);
        check("rst_ready", bus.req_ready, 1);
        check("rst_valid", bus.resp_valid, 0);
        check("rst_time", bus.time_now, 0);
        check("rst_occ", bus.occupied, 0);
        check("rst_full", bus.full, 0);
        check("rst_fee", bus.fee, 0);
        check("rst_total", bus.time_total, 0);
        rst = 1'b0;

        wait_time(4);
        issue(1, 0, 0);
        wait_time(12);
        issue(0, 1, 0);

        for (int i = 0; i < 5; i++) issue(1, 0, 0);
        issue(0, 1, 2);
        issue(1, 0, 0);
        for (int i = 0; i < NS; i++) issue(0, 1, i);

        wait_time(250);
        issue(1, 0, 0);
        wait_time(6);
        issue(0, 1, 0);

        t0 = mtime();
        issue(1, 0, 0);
        wait_time((t0 + 200) % 256);
        issue(0, 1, 0);

        issue(1, 1, 3);
        issue(1, 0, 0);

        for (int k = 0; k < 80; k++) begin
            repeat ($urandom_range(0, 15)) @(negedge clk);
            r = $urandom_range(0, 9);
            s = $urandom_range(0, NS - 1);
            if (r < 5)       issue(1, 0, 0);
            else if (r < 9)  issue(0, 1, s);
            else begin
                issue(1, 1, s);
                issue(1, 0, 0);
            end
        end

        if (!m_occ[0]) issue(1, 0, 0);
        bus.exit_req  = 1'b1;
        bus.exit_slot = 2'd0;
        @(negedge clk);
        bus.exit_req = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < NS; i++) m_occ[i] = 0;
        @(negedge clk);
        check("rst_calc_valid0", bus.resp_valid, 0);
        @(negedge clk);
        check("rst_calc_valid1", bus.resp_valid, 0);
        rst = 1'b0;
        check("rst_calc_occ", bus.occupied, mocc());
        check("rst_calc_ready", bus.req_ready, 1);
        check("rst_calc_time", bus.time_now, 0);
        check("rst_calc_err", bus.resp_err, 0);
        check("rst_calc_total", bus.time_total, 0);
        check("rst_calc_fee", bus.fee, 0);
        @(negedge clk);
        check("post_rst_valid", bus.resp_valid, 0);
        check("post_rst_time", bus.time_now, mtime());
        issue(1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
